// File: rtl/itof_pipe.sv
// itof_pipe: three-stage signed int32 to IEEE-754 single-precision converter with valid/ready flow control.
// Stage 1 takes the magnitude, stage 2 left-normalises it, stage 3 rounds to nearest-even and packs.
module itof_pipe (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    input  logic [31:0] in_x,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_y
);

    // Position of the most significant set bit; an all-zero input is flagged separately.
    function automatic logic [4:0] msb_pos(input logic [31:0] v);
        logic [4:0] pos;
        pos = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) begin
                pos = 5'(i);
            end else begin
                pos = pos;
            end
        end
        return pos;
    endfunction

    logic        en_s;

    logic        v1_q, v1_d;
    logic        s1_q, s1_d;
    logic [31:0] abs1_q, abs1_d;

    logic        v2_q, v2_d;
    logic        s2_q, s2_d;
    logic        z2_q, z2_d;
    logic [7:0]  e2_q, e2_d;
    logic [31:0] n2_q, n2_d;

    logic        v3_q, v3_d;
    logic [31:0] y3_q, y3_d;

    logic [4:0]  pos_s;
    logic [22:0] frac_s;
    logic        guard_s;
    logic        sticky_s;
    logic        inc_s;
    logic [23:0] sum_s;

    assign en_s      = !v3_q || out_ready;
    assign in_ready  = en_s;
    assign out_valid = v3_q;
    assign out_y     = y3_q;

    // Stage 1 next state: sign and 32-bit unsigned magnitude (-2^31 maps to 0x80000000).
    always_comb begin
        v1_d   = in_valid;
        s1_d   = in_x[31];
        abs1_d = in_x;
        if (in_x[31]) begin
            abs1_d = 32'd0 - in_x;
        end else begin
            abs1_d = in_x;
        end
    end

    // Stage 2 next state: exponent from MSB position and magnitude shifted so the MSB sits at bit 31.
    always_comb begin
        pos_s = msb_pos(abs1_q);
        v2_d  = v1_q;
        s2_d  = s1_q;
        z2_d  = (abs1_q == 32'd0);
        e2_d  = 8'd127 + {3'd0, pos_s};
        n2_d  = abs1_q << (5'd31 - pos_s);
    end

    // Stage 3 next state: round-to-nearest-even on the 23 bits below the hidden one, then pack.
    always_comb begin
        frac_s   = n2_q[30:8];
        guard_s  = n2_q[7];
        sticky_s = |n2_q[6:0];
        inc_s    = guard_s && (sticky_s || frac_s[0]);
        sum_s    = {1'b0, frac_s} + {23'd0, inc_s};
        v3_d     = v2_q;
        y3_d     = 32'd0;
        if (z2_q) begin
            y3_d = 32'd0;
        end else if (sum_s[23]) begin
            y3_d = {s2_q, e2_q + 8'd1, 23'd0};
        end else begin
            y3_d = {s2_q, e2_q, sum_s[22:0]};
        end
    end

    // Pipeline registers: every stage advances together on en_s and holds otherwise.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v1_q   <= 1'b0;
            s1_q   <= 1'b0;
            abs1_q <= 32'd0;
            v2_q   <= 1'b0;
            s2_q   <= 1'b0;
            z2_q   <= 1'b0;
            e2_q   <= 8'd0;
            n2_q   <= 32'd0;
            v3_q   <= 1'b0;
            y3_q   <= 32'd0;
        end else if (en_s) begin
            v1_q   <= v1_d;
            s1_q   <= s1_d;
            abs1_q <= abs1_d;
            v2_q   <= v2_d;
            s2_q   <= s2_d;
            z2_q   <= z2_d;
            e2_q   <= e2_d;
            n2_q   <= n2_d;
            v3_q   <= v3_d;
            y3_q   <= y3_d;
        end else begin
            v1_q   <= v1_q;
            s1_q   <= s1_q;
            abs1_q <= abs1_q;
            v2_q   <= v2_q;
            s2_q   <= s2_q;
            z2_q   <= z2_q;
            e2_q   <= e2_q;
            n2_q   <= n2_q;
            v3_q   <= v3_q;
            y3_q   <= y3_q;
        end
    end

endmodule
